dot_product_ctrl: RTL and testbench
===================================

# dot_product_ctrl

Sequencing and accumulation stage wrapped around the shared `Multiplier` (start/ready, N-bit unsigned operands, 2N-bit product).
- Accepts a stream of operand pairs over a valid/ready handshake.
- Issues one multiply per pair and sums the products into a wide accumulator.
- Emits the dot product when the pair flagged `in_last` completes.
- It is the multiplier's direct upstream driver and downstream consumer.

## Interface
- `N`, 8: operand width; must match the attached `Multiplier`.
- `ACC_W`, 24: accumulator width, must be ≥ 2N.
- `CNT_W`, 8: term counter width.

- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: operand pair present.
- `in_ready` out 1: block can accept a pair.
- `in_a` in N: first operand.
- `in_b` in N: second operand.
- `in_last` in 1: pair is the final term of the vector.
- `mul_start` out 1: start pulse to `Multiplier.start`.
- `mul_multiplier` out N: to `Multiplier.multiplier`.
- `mul_multiplicand` out N: to `Multiplier.multiplicand`.
- `mul_product` in 2N: from `Multiplier.product`.
- `mul_ready` in 1: from `Multiplier.ready`.
- `acc_out` out ACC_W: final dot product, held until the next vector completes.
- `acc_valid` out 1: one-cycle pulse when `acc_out` updates.
- `acc_overflow` out 1: the vector's sum exceeded ACC_W bits; updates with `acc_out`.
- `term_count` out CNT_W: number of terms in the last completed vector; saturates at all-ones.

## Operation
- **States:** IDLE, ISSUE, GUARD, WAIT, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready`: latch `in_a`→`mul_multiplier`, `in_b`→`mul_multiplicand`, and `in_last` internally; go to ISSUE.
  - `mul_ready` is ignored.
- **ISSUE:** `mul_start`=1 for exactly this one cycle; go to GUARD.
- **GUARD:** one cycle, ignores stale `mul_ready`; go to WAIT.
- **WAIT**
  - Hold until `mul_ready`=1.
  - On that edge: `acc_int += zero_extend(mul_product)` and increment the internal count (saturating).
  - If the latched last flag is set, go to DONE; otherwise go to IDLE.
- **DONE**
  - Copy `acc_int`, the sticky overflow and the count into `acc_out`, `acc_overflow`, `term_count`.
  - `acc_valid`=1 for this cycle.
  - Clear `acc_int`, the overflow flag and the count; go to IDLE.
- **Width rule:** compute the sum in ACC_W+1 bits. A carry out sets the sticky overflow for the current vector.
- **Operand stability:** `mul_multiplier` and `mul_multiplicand` stay stable from ISSUE through WAIT.
- **Backpressure:** `in_valid` while `in_ready`=0 is not accepted; upstream holds it. Each pair is accepted exactly once.
- **Reset (`rst_n`=0 at an edge)**
  - Applies in any state, including mid-vector: go to IDLE and discard the partial sum.
  - Outputs after reset: `mul_start`=0; `in_ready`=0 while `rst_n`=0 and 1 from the first cycle after release.
  - `acc_out`, `acc_valid`, `acc_overflow`, `term_count`, `mul_multiplier`, `mul_multiplicand` all 0.
  - The `Multiplier` shares `rst_n`.

## Timing
- **Accepting edge E0:** ISSUE in [E0,E1), `mul_start` high exactly one cycle, GUARD in [E1,E2), WAIT from E2.
- **First ready edge Ew** (first edge in WAIT with `mul_ready`=1):
  - Non-last term: IDLE from Ew, so the next pair can be accepted at Ew+1.
  - Last term: DONE in [Ew,Ew+1) with `acc_valid`=1; IDLE from Ew+1.
- **Per-term overhead:** 3 cycles plus the multiplier latency.
- **Output hold:** `acc_out`, `acc_overflow` and `term_count` hold their values from DONE until the next DONE.

## Configuration
- Macro: `DOT_PRODUCT_SATURATE_EN`.
- **Defined:** on carry out, `acc_int` clamps to all-ones and stays there for the rest of the vector; `acc_overflow` is reported as 1.
- **Undefined:** `acc_int` wraps modulo 2^ACC_W; `acc_overflow` is reported as 1.

## Test plan
- **Single term:** pair 0x0F,0x0A with last=1 → `acc_out`=0x000096, `term_count`=1, `acc_overflow`=0, `acc_valid` high exactly one cycle.
- **Three terms:** (3,4), (5,6), (0xFF,0xFF, last) → `acc_out`=0x00FE2B, `term_count`=3; `mul_start` high exactly one cycle per term.
- **Overflow, `ACC_W`=16:** (0xFF,0xFF), (0xFF,0xFF, last) → `acc_overflow`=1.
  - Without the macro: `acc_out`=0xFC02.
  - With `DOT_PRODUCT_SATURATE_EN`: `acc_out`=0xFFFF.
- **Back-to-back vectors:** (2,3, last) then (2,2, last) → `acc_out`=6, then 4; no carry-over between vectors; overflow clears.
- **Reset mid-WAIT:** pull `rst_n` low one cycle during WAIT → all outputs 0; `in_ready`=1 the cycle after release; then (1,1, last) → `acc_out`=1, `term_count`=1.
- **Backpressure:** hold `in_valid`=1 continuously across a 2-term vector → exactly 2 handshakes, exactly 2 `mul_start` pulses, `in_ready`=0 outside IDLE.

Source files
------------

// File: rtl/dot_product_ctrl.sv
// Sequencer/accumulator driving a start/ready multiplier and summing products into a dot product.
// Optional DOT_PRODUCT_SATURATE_EN: clamp the accumulator on carry-out instead of wrapping.
module dot_product_ctrl #(
  parameter int unsigned N     = 8,
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             in_last,
  output logic             mul_start,
  output logic [N-1:0]     mul_multiplier,
  output logic [N-1:0]     mul_multiplicand,
  input  logic [2*N-1:0]   mul_product,
  input  logic             mul_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  output logic             acc_overflow,
  output logic [CNT_W-1:0] term_count
);

  localparam int unsigned PadW = ACC_W + 1 - 2 * N;

  typedef enum logic [2:0] {StIdle, StIssue, StGuard, StWait, StDone} state_e;

  state_e             state_q, state_d;
  logic [N-1:0]       op_a_q, op_a_d, op_b_q, op_b_d;
  logic               last_q, last_d;
  logic [ACC_W-1:0]   acc_q, acc_d, acc_out_q, acc_out_d;
  logic               ovf_q, ovf_d, ovf_out_q, ovf_out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_out_q, cnt_out_d;
  logic [ACC_W:0]     sum;

  assign sum = {1'b0, acc_q} + {{PadW{1'b0}}, mul_product};

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    last_d    = last_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    acc_out_d = acc_out_q;
    ovf_out_d = ovf_out_q;
    cnt_out_d = cnt_out_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_a_d  = in_a;
          op_b_d  = in_b;
          last_d  = in_last;
          state_d = StIssue;
        end
      end
      StIssue: state_d = StGuard;
      // Ready may still reflect the previous operation for one cycle after start.
      StGuard: state_d = StWait;
      StWait: begin
        if (mul_ready) begin
          if (sum[ACC_W]) begin
            ovf_d = 1'b1;
`ifdef DOT_PRODUCT_SATURATE_EN
            acc_d = {ACC_W{1'b1}};
`else
            acc_d = sum[ACC_W-1:0];
`endif
          end else begin
            acc_d = sum[ACC_W-1:0];
          end
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
          state_d = last_q ? StDone : StIdle;
        end
      end
      StDone: begin
        acc_out_d = acc_q;
        ovf_out_d = ovf_q;
        cnt_out_d = cnt_q;
        acc_d     = '0;
        ovf_d     = 1'b0;
        cnt_d     = '0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_a_q    <= '0;
      op_b_q    <= '0;
      last_q    <= 1'b0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      acc_out_q <= '0;
      ovf_out_q <= 1'b0;
      cnt_out_q <= '0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      last_q    <= last_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      acc_out_q <= acc_out_d;
      ovf_out_q <= ovf_out_d;
      cnt_out_q <= cnt_out_d;
    end
  end

  // Result is visible during DONE alongside acc_valid, then held in the output registers.
  always_comb begin
    in_ready         = rst_n && (state_q == StIdle);
    mul_start        = (state_q == StIssue);
    mul_multiplier   = op_a_q;
    mul_multiplicand = op_b_q;
    acc_valid        = (state_q == StDone);
    acc_out          = acc_valid ? acc_q : acc_out_q;
    acc_overflow     = acc_valid ? ovf_q : ovf_out_q;
    term_count       = acc_valid ? cnt_q : cnt_out_q;
  end

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Directed bench for dot_product_ctrl with a behavioural start/ready multiplier (latency 4).
module tb_dot_product_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_last;
  logic [7:0]  in_a, in_b;
  logic        in_ready, mul_start, acc_valid, acc_overflow, mul_ready;
  logic [7:0]  mul_multiplier, mul_multiplicand, term_count;
  logic [15:0] mul_product;
  logic [23:0] acc_out;
  // Narrow-accumulator instance sharing stimulus and multiplier responses
  logic        in_ready16, mul_start16, acc_valid16, acc_overflow16;
  logic [7:0]  mul_multiplier16, mul_multiplicand16, term_count16;
  logic [15:0] acc_out16;

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt, hs_cnt, busy;
  logic done_seen;

  always #5 clk = ~clk;

  dot_product_ctrl #(.N(8), .ACC_W(24), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
    .in_b(in_b), .in_last(in_last), .mul_start(mul_start), .mul_multiplier(mul_multiplier),
    .mul_multiplicand(mul_multiplicand), .mul_product(mul_product), .mul_ready(mul_ready),
    .acc_out(acc_out), .acc_valid(acc_valid), .acc_overflow(acc_overflow),
    .term_count(term_count)
  );

  dot_product_ctrl #(.N(8), .ACC_W(16), .CNT_W(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16), .in_a(in_a),
    .in_b(in_b), .in_last(in_last), .mul_start(mul_start16),
    .mul_multiplier(mul_multiplier16), .mul_multiplicand(mul_multiplicand16),
    .mul_product(mul_product), .mul_ready(mul_ready), .acc_out(acc_out16),
    .acc_valid(acc_valid16), .acc_overflow(acc_overflow16), .term_count(term_count16)
  );

  // Multiplier model: ready idles high, drops after start, returns with product 4 edges later
  always @(posedge clk) begin
    if (!rst_n) begin
      mul_ready   <= 1'b1;
      mul_product <= '0;
      busy        <= 0;
    end else if (mul_start) begin
      mul_ready <= 1'b0;
      busy      <= 3;
    end else if (busy == 1) begin
      mul_ready   <= 1'b1;
      mul_product <= 16'(mul_multiplier) * 16'(mul_multiplicand);
      busy        <= 0;
    end else if (busy > 1) begin
      busy <= busy - 1;
    end
  end

  always @(posedge clk) begin
    if (mul_start) start_cnt++;
    if (in_valid && in_ready) hs_cnt++;
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
    int t;
    @(negedge clk);
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    done_seen = 1'b0;
    t = 0;
    while (!acc_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    done_seen = acc_valid;
  endtask

  task automatic test_reset();
    n_checks++;
    if (in_ready !== 1'b0 || mul_start !== 1'b0 || acc_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: in_ready=%b mul_start=%b acc_valid=%b, want 0 0 0",
               in_ready, mul_start, acc_valid);
    end
    n_checks++;
    if (acc_out !== 24'h0 || acc_overflow !== 1'b0 || term_count !== 8'h0 ||
        mul_multiplier !== 8'h0 || mul_multiplicand !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_data: acc=%h ovf=%b cnt=%h mpr=%h mcd=%h, want all 0",
               acc_out, acc_overflow, term_count, mul_multiplier, mul_multiplicand);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_single();
    start_cnt = 0;
    send(8'h0F, 8'h0A, 1'b1);
    n_checks++;
    if (mul_start !== 1'b1 || mul_multiplier !== 8'h0F || mul_multiplicand !== 8'h0A ||
        in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_issue: start=%b mpr=%h mcd=%h rdy=%b want 1 0f 0a 0",
               mul_start, mul_multiplier, mul_multiplicand, in_ready);
    end
    wait_done();
    n_checks++;
    if (done_seen !== 1'b1 || acc_out !== 24'h000096 || term_count !== 8'd1 ||
        acc_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL single_result: done=%b acc=%h cnt=%0d ovf=%b want 1 000096 1 0",
               done_seen, acc_out, term_count, acc_overflow);
    end
    @(negedge clk);
    n_checks++;
    if (acc_valid !== 1'b0 || acc_out !== 24'h000096 || start_cnt != 1) begin
      n_fail++;
      $display("FAIL single_pulse_hold: valid=%b acc=%h starts=%0d want 0 000096 1",
               acc_valid, acc_out, start_cnt);
    end
  endtask

  task automatic test_three_terms();
    start_cnt = 0;
    send(8'd3, 8'd4, 1'b0);
    send(8'd5, 8'd6, 1'b0);
    send(8'hFF, 8'hFF, 1'b1);
    wait_done();
    n_checks++;
    if (done_seen !== 1'b1 || acc_out !== 24'h00FE2B || term_count !== 8'd3 ||
        acc_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL three_result: done=%b acc=%h cnt=%0d ovf=%b want 1 00fe2b 3 0",
               done_seen, acc_out, term_count, acc_overflow);
    end
    n_checks++;
    if (start_cnt != 3) begin
      n_fail++;
      $display("FAIL three_starts: got %0d want 3", start_cnt);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] exp16;
`ifdef DOT_PRODUCT_SATURATE_EN
    exp16 = 16'hFFFF;
`else
    exp16 = 16'hFC02;
`endif
    send(8'hFF, 8'hFF, 1'b0);
    send(8'hFF, 8'hFF, 1'b1);
    wait_done();
    n_checks++;
    if (done_seen !== 1'b1 || acc_out16 !== exp16 || acc_overflow16 !== 1'b1 ||
        term_count16 !== 8'd2) begin
      n_fail++;
      $display("FAIL overflow_w16: done=%b acc=%h ovf=%b cnt=%0d want 1 %h 1 2",
               done_seen, acc_out16, acc_overflow16, term_count16, exp16);
    end
    n_checks++;
    if (acc_out !== 24'h01FC02 || acc_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_w24: acc=%h ovf=%b want 01fc02 0", acc_out, acc_overflow);
    end
  endtask

  task automatic test_back_to_back();
    send(8'd2, 8'd3, 1'b1);
    wait_done();
    n_checks++;
    if (done_seen !== 1'b1 || acc_out !== 24'd6 || term_count !== 8'd1 ||
        acc_overflow16 !== 1'b0 || acc_out16 !== 16'd6) begin
      n_fail++;
      $display("FAIL b2b_first: done=%b acc=%0d cnt=%0d ovf16=%b acc16=%0d want 1 6 1 0 6",
               done_seen, acc_out, term_count, acc_overflow16, acc_out16);
    end
    send(8'd2, 8'd2, 1'b1);
    wait_done();
    n_checks++;
    if (done_seen !== 1'b1 || acc_out !== 24'd4 || term_count !== 8'd1 ||
        acc_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second: done=%b acc=%0d cnt=%0d ovf=%b want 1 4 1 0",
               done_seen, acc_out, term_count, acc_overflow);
    end
  endtask

  task automatic test_reset_mid_wait();
    send(8'hFF, 8'hFF, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0 || acc_out !== 24'h0 || acc_valid !== 1'b0 ||
        acc_overflow !== 1'b0 || term_count !== 8'h0 || mul_multiplier !== 8'h0 ||
        mul_multiplicand !== 8'h0 || mul_start !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: rdy=%b acc=%h v=%b ovf=%b cnt=%h mpr=%h mcd=%h st=%b",
               in_ready, acc_out, acc_valid, acc_overflow, term_count, mul_multiplier,
               mul_multiplicand, mul_start);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_ready: got %b want 1", in_ready);
    end
    send(8'd1, 8'd1, 1'b1);
    wait_done();
    n_checks++;
    if (done_seen !== 1'b1 || acc_out !== 24'd1 || term_count !== 8'd1) begin
      n_fail++;
      $display("FAIL midreset_after: done=%b acc=%h cnt=%0d want 1 000001 1",
               done_seen, acc_out, term_count);
    end
  endtask

  task automatic test_backpressure();
    int t;
    int busy_ready;
    start_cnt = 0;
    hs_cnt = 0;
    busy_ready = 0;
    @(negedge clk);
    in_a = 8'd1; in_b = 8'd2; in_last = 1'b0; in_valid = 1'b1;
    t = 0;
    while (hs_cnt < 1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    in_a = 8'd3; in_b = 8'd4; in_last = 1'b1;
    t = 0;
    while (!acc_valid && t < 80) begin
      if (in_ready && hs_cnt >= 2) busy_ready++;
      @(negedge clk);
      t++;
    end
    done_seen = acc_valid;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_ready_in_done: got %b want 0", in_ready);
    end
    in_valid = 1'b0;
    n_checks++;
    if (done_seen !== 1'b1 || acc_out !== 24'd14 || term_count !== 8'd2) begin
      n_fail++;
      $display("FAIL bp_result: done=%b acc=%0d cnt=%0d want 1 14 2",
               done_seen, acc_out, term_count);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (hs_cnt != 2 || start_cnt != 2 || busy_ready != 0) begin
      n_fail++;
      $display("FAIL bp_counts: handshakes=%0d starts=%0d ready_while_busy=%0d want 2 2 0",
               hs_cnt, start_cnt, busy_ready);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
    start_cnt = 0; hs_cnt = 0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_three_terms();
    test_overflow();
    test_back_to_back();
    test_reset_mid_wait();
    test_backpressure();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
